// File: rtl/rs_syndrome_serial_if.sv
// -----------------------------------------------------------------------------
// rs_syndrome_serial_if
//   Symbol-stream and syndrome-result handshake bundle for rs_syndrome_serial.
//   Parameters:
//     SYMBOL_WIDTH  bits per GF symbol
//     NSYN          number of syndromes carried on syn
//   Signals:
//     in_sym / in_valid / in_ready     received-symbol stream (producer -> block)
//     syn / syn_zero / out_valid       completed syndrome vector (block -> consumer)
//     out_ready                        consumer takes syn this cycle
//   Modports:
//     master  producer/consumer side (testbench or surrounding datapath)
//     slave   the syndrome calculator itself
// -----------------------------------------------------------------------------
interface rs_syndrome_serial_if #(
    parameter int SYMBOL_WIDTH = 8,
    parameter int NSYN         = 2
);
    logic [SYMBOL_WIDTH-1:0]      in_sym;
    logic                         in_valid;
    logic                         in_ready;
    logic [NSYN*SYMBOL_WIDTH-1:0] syn;
    logic                         syn_zero;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_sym, in_valid, out_ready,
        input  in_ready, syn, syn_zero, out_valid
    );

    modport slave (
        input  in_sym, in_valid, out_ready,
        output in_ready, syn, syn_zero, out_valid
    );
endinterface

// File: rtl/rs_syndrome_serial.sv
// -----------------------------------------------------------------------------
// rs_syndrome_serial
//   Streaming Reed-Solomon syndrome calculator over GF(2^SYMBOL_WIDTH).
//   Takes one received symbol per accepted transfer, highest-degree coefficient
//   first, and evaluates S_j = v(alpha^(FCR+j-1)), j = 1..N-K, by Horner
//   accumulation. The finished syndrome vector sits in a one-deep output buffer
//   with a valid/ready handshake.
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous active-low reset
//     bus        rs_syndrome_serial_if.slave (in_sym/in_valid/in_ready,
//                syn/syn_zero/out_valid/out_ready); S_1 in syn[m-1:0]
//     err_count  16-bit saturating count of completions with a nonzero
//                syndrome vector; present only when RS_SYN_ERR_CNT_EN is defined
//
//   Optional feature macro: RS_SYN_ERR_CNT_EN
// -----------------------------------------------------------------------------
module rs_syndrome_serial #(
    parameter int                    SYMBOL_WIDTH = 8,
    parameter int                    N            = 18,
    parameter int                    K            = 16,
    parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 'h11D,
    parameter int                    FCR          = 1
) (
    input logic                 clk,
    input logic                 reset,
    rs_syndrome_serial_if.slave bus
`ifdef RS_SYN_ERR_CNT_EN
    ,
    output logic [15:0]         err_count
`endif
);
    localparam int M     = SYMBOL_WIDTH;
    localparam int NSYN  = N - K;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    // Multiply by alpha (x) modulo the primitive polynomial.
    function automatic logic [M-1:0] xtime(input logic [M-1:0] x);
        return {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM_POLY[M-1:0] : '0);
    endfunction

    // Shift-and-add GF multiply; with b a constant this reduces to an XOR network.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p;
        logic [M-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // alpha^e, evaluated at elaboration for the root constants.
    function automatic logic [M-1:0] alpha_pow(input int e);
        logic [M-1:0] r;
        int           n;
        r = {{(M-1){1'b0}}, 1'b1};
        n = e % ((1 << M) - 1);
        for (int i = 0; i < n; i++) r = xtime(r);
        return r;
    endfunction

    logic [CNT_W-1:0]          sym_cnt;
    logic [NSYN-1:0][M-1:0]    acc;
    logic [NSYN-1:0][M-1:0]    acc_next;
    logic [NSYN-1:0][M-1:0]    syn_q;
    logic                      syn_zero_q;
    logic                      out_valid_q;
    logic                      last;
    logic                      xfer;
    logic                      done;

    assign last = (sym_cnt == LAST);

    // Only the final symbol of a codeword can stall: it needs the output buffer free.
    assign bus.in_ready = !(last && out_valid_q && !bus.out_ready);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign done         = xfer && last;

    // Horner step per syndrome; the first symbol of a codeword seeds the
    // accumulator directly, so nothing from the previous codeword leaks in.
    for (genvar j = 0; j < NSYN; j++) begin : g_root
        localparam logic [M-1:0] ROOT = alpha_pow(FCR + j);
        assign acc_next[j] = (sym_cnt == '0) ? bus.in_sym
                                             : (gf_mul(acc[j], ROOT) ^ bus.in_sym);
    end

    // NOTE: state updates use <= so every flop samples pre-edge values;
    // blocking assignments here would chain updates within one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_cnt     <= '0;
            // NOTE: the accumulators and syn buffer are a handful of flops, not a
            // RAM, so they take the async reset like any other register.
            acc         <= '0;
            syn_q       <= '0;
            syn_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (xfer) begin
                acc     <= acc_next;
                sym_cnt <= last ? '0 : sym_cnt + 1'b1;
            end
            // A new completion takes priority over consumption so back-to-back
            // codewords keep out_valid high while fresh data loads.
            if (done) begin
                syn_q       <= acc_next;
                syn_zero_q  <= (acc_next == '0);
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.syn       = syn_q;
    assign bus.syn_zero  = syn_zero_q;
    assign bus.out_valid = out_valid_q;

`ifdef RS_SYN_ERR_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (done && (acc_next != '0) && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
